// File: rtl/hbram_emu_pkg.sv
// Shared types and constants for the HyperBus RAM target emulator.
package hbram_emu_pkg;

  // Device-side transaction states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LAT,
    ST_WDATA,
    ST_RDATA,
    ST_REGW,
    ST_HOLD
  } state_t;

  // Command/address bit positions within the 48-bit CA word.
  localparam int CA_RW_BIT = 47;  // 1 = read
  localparam int CA_AS_BIT = 46;  // 1 = register space
  localparam int CA_BT_BIT = 45;  // 1 = linear burst, 0 = wrapped

  // Full word-address width carried through a burst; memory uses the low bits.
  localparam int ADDR_W = 32;

  // Configuration register word addresses in register space.
  localparam logic [ADDR_W-1:0] CR0_ADDR = 32'h0000_0800;
  localparam logic [ADDR_W-1:0] CR1_ADDR = 32'h0000_0801;

  // One read-path output beat (DQ halves plus RWDS halves).
  typedef struct packed {
    logic [7:0] dq_hi;
    logic [7:0] dq_lo;
    logic       rwds_hi;
    logic       rwds_lo;
  } rd_out_t;

  // Wrapped-burst group size in words, selected by CR0[1:0].
  function automatic logic [6:0] wrap_words(input logic [1:0] burst_len);
    case (burst_len)
      2'b00:   return 7'd64;
      2'b01:   return 7'd32;
      2'b10:   return 7'd8;
      default: return 7'd16;
    endcase
  endfunction

endpackage

// File: rtl/hbram_emu_mem.sv
// Backing store: 2^AW x 16-bit single-clock RAM with per-byte write enables
// and a registered (1-cycle) read port.
module hbram_emu_mem #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [1:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [1:0][7:0] mem [2**AW];

  // Byte-lane writes and registered read on the same clock.
  // NOTE: the array has no reset so it maps onto block RAM, and all state
  // here updates with <= so reads and writes in one cycle see the old value.
  always_ff @(posedge clk) begin
    if (we) begin
      if (be[0]) mem[waddr][0] <= wdata[7:0];
      if (be[1]) mem[waddr][1] <= wdata[15:8];
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/hbram_target_emu.sv
// HyperBus RAM target emulator. Sits on the controller's DDIO-level hbc_*
// signals, decodes the 48-bit CA, applies initial latency and serves memory
// and CR0/CR1 accesses from an internal byte-enabled RAM.
module hbram_target_emu
  import hbram_emu_pkg::*;
#(
  parameter int          MEM_AW    = 10,
  parameter int          LATENCY   = 6,
  parameter int          FIXED_LAT = 1,
  parameter int          RD_DLY    = 0,
  parameter logic [15:0] CFG_CR0   = 16'h8F1F,
  parameter logic [15:0] CFG_CR1   = 16'h0002
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hb_rst_n,
  input  logic        hb_cs_n,
  input  logic        hb_ck_hi,
  input  logic        hb_ck_lo,
  input  logic [7:0]  hb_dq_o_hi,
  input  logic [7:0]  hb_dq_o_lo,
  input  logic [7:0]  hb_dq_oe,
  input  logic        hb_rwds_o_hi,
  input  logic        hb_rwds_o_lo,
  output logic [7:0]  hb_dq_i_hi,
  output logic [7:0]  hb_dq_i_lo,
  output logic        hb_rwds_i_hi,
  output logic        hb_rwds_i_lo,
  output logic [15:0] cr0,
  output logic [15:0] cr1,
  output logic        busy,
  output logic        err
);

  localparam int N_LAT = LATENCY * ((FIXED_LAT != 0) ? 2 : 1);
  localparam int LAT_W = (N_LAT > 1) ? $clog2(N_LAT) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(N_LAT - 1);
  localparam logic              CA_RWDS  = (FIXED_LAT != 0);
  localparam logic [ADDR_W-1:0] LIN_MASK = ADDR_W'((64'd1 << MEM_AW) - 64'd1);

  state_t              state;
  logic [1:0]          ca_cnt;
  logic [31:0]         ca_sr;
  logic [47:0]         ca_full;
  logic [ADDR_W-1:0]   ca_addr;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   adv_mask;
  logic [ADDR_W-1:0]   next_addr;
  logic                is_read;
  logic                is_reg;
  logic                is_lin;
  logic [LAT_W-1:0]    lat_cnt;
  logic [15:0]         cr0_q;
  logic [15:0]         cr1_q;
  logic [15:0]         reg_rd;
  logic [15:0]         rd_word;
  logic [15:0]         mem_q;
  logic [15:0]         wdata;
  logic                active;
  logic                mem_we;
  logic [1:0]          mem_be;
  logic [MEM_AW-1:0]   mem_raddr;
  rd_out_t             out0;
  rd_out_t             out_q;

  // One ck cycle is active when ck_p is high in the first half and low in
  // the second; anything else is a stalled clock and freezes progress.
  assign active  = hb_ck_hi & ~hb_ck_lo;
  assign wdata   = {hb_dq_o_hi, hb_dq_o_lo};
  assign ca_full = {ca_sr, hb_dq_o_hi, hb_dq_o_lo};
  assign ca_addr = {ca_full[44:16], ca_full[2:0]};
  assign mem_be  = {~hb_rwds_o_hi, ~hb_rwds_o_lo};
  assign mem_we  = (state == ST_WDATA) && active && !hb_cs_n && hb_rst_n && !is_reg;

  // DQ output enable and reserved CA bits carry no meaning for the target.
  logic unused_ok;
  assign unused_ok = ^{hb_dq_oe, ca_full[15:3]};

  // Address sequencing, read-port address and read-data selection.
  always_comb begin
    // NOTE: every always_comb output is defaulted first so no path infers a latch.
    adv_mask  = LIN_MASK;
    reg_rd    = '0;
    mem_raddr = addr[MEM_AW-1:0];
    if (!is_lin) adv_mask = ADDR_W'(wrap_words(cr0_q[1:0]) - 7'd1);
    // Bits outside the mask stay put; bits inside count and wrap.
    next_addr = (addr & ~adv_mask) | ((addr + ADDR_W'(1)) & adv_mask);
    // While a read beat is consumed, fetch the following word so the next
    // active cycle finds it already in the RAM output register.
    if (state == ST_RDATA && active) mem_raddr = next_addr[MEM_AW-1:0];
    if (addr == CR0_ADDR)      reg_rd = cr0_q;
    else if (addr == CR1_ADDR) reg_rd = cr1_q;
    rd_word = is_reg ? reg_rd : mem_q;
  end

  hbram_emu_mem #(
    .AW (MEM_AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .be    (mem_be),
    .waddr (addr[MEM_AW-1:0]),
    .wdata (wdata),
    .raddr (mem_raddr),
    .rdata (mem_q)
  );

  // Transaction FSM with registered read beat, CR0/CR1 and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ca_cnt  <= '0;
      ca_sr   <= '0;
      addr    <= '0;
      is_read <= 1'b0;
      is_reg  <= 1'b0;
      is_lin  <= 1'b0;
      lat_cnt <= '0;
      cr0_q   <= CFG_CR0;
      cr1_q   <= CFG_CR1;
      busy    <= 1'b0;
      err     <= 1'b0;
      out0    <= '0;
    end else begin
      // RWDS and DQ return to zero unless a state below drives them.
      out0 <= '0;
      if (!hb_rst_n) begin
        // Device reset: abort, reload config; memory contents survive.
        state <= ST_IDLE;
        busy  <= 1'b0;
        cr0_q <= CFG_CR0;
        cr1_q <= CFG_CR1;
      end else if (hb_cs_n) begin
        // Deselect ends any transaction; words already written remain.
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (active) begin
              ca_sr        <= {ca_sr[15:0], wdata};
              ca_cnt       <= 2'd1;
              state        <= ST_CA;
              busy         <= 1'b1;
              out0.rwds_hi <= CA_RWDS;
              out0.rwds_lo <= CA_RWDS;
            end
          end
          ST_CA: begin
            if (active && ca_cnt == 2'd2) begin
              is_read <= ca_full[CA_RW_BIT];
              is_reg  <= ca_full[CA_AS_BIT];
              is_lin  <= ca_full[CA_BT_BIT];
              addr    <= ca_addr;
              if (!ca_full[CA_RW_BIT] && ca_full[CA_AS_BIT]) begin
                state <= ST_REGW;
              end else begin
                state   <= ST_LAT;
                lat_cnt <= LAT_LAST;
              end
            end else begin
              out0.rwds_hi <= CA_RWDS;
              out0.rwds_lo <= CA_RWDS;
              if (active) begin
                ca_sr  <= {ca_sr[15:0], wdata};
                ca_cnt <= ca_cnt + 2'd1;
              end
            end
          end
          ST_LAT: begin
            if (active) begin
              if (lat_cnt == '0) state <= is_read ? ST_RDATA : ST_WDATA;
              else               lat_cnt <= lat_cnt - 1'b1;
            end
          end
          ST_WDATA: begin
            if (active) begin
              // Register space cannot take burst data here.
              if (is_reg) err <= 1'b1;
              addr <= next_addr;
            end
          end
          ST_RDATA: begin
            if (active) begin
              out0.dq_hi   <= rd_word[15:8];
              out0.dq_lo   <= rd_word[7:0];
              out0.rwds_hi <= 1'b1;
              out0.rwds_lo <= 1'b0;
              addr         <= next_addr;
            end
          end
          ST_REGW: begin
            if (active) begin
              if (addr == CR0_ADDR)      cr0_q <= wdata;
              else if (addr == CR1_ADDR) cr1_q <= wdata;
              else                       err   <= 1'b1;
              state <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            state <= ST_HOLD;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Optional extra stages on the read data / RWDS return path.
  generate
    if (RD_DLY == 0) begin : g_no_dly
      assign out_q = out0;
    end else begin : g_dly
      rd_out_t pipe [RD_DLY];
      // Shift each beat through RD_DLY registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < RD_DLY; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= out0;
          for (int i = 1; i < RD_DLY; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign out_q = pipe[RD_DLY-1];
    end
  endgenerate

  assign hb_dq_i_hi   = out_q.dq_hi;
  assign hb_dq_i_lo   = out_q.dq_lo;
  assign hb_rwds_i_hi = out_q.rwds_hi;
  assign hb_rwds_i_lo = out_q.rwds_lo;
  assign cr0          = cr0_q;
  assign cr1          = cr1_q;

endmodule

// File: tb/tb_hbram_target_emu.sv
// Directed bench for hbram_target_emu with default parameters
// (LATENCY=6, FIXED_LAT=1 -> 12 latency cycles, RD_DLY=0, MEM_AW=10).
module tb_hbram_target_emu;

  localparam int N_LAT = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hb_rst_n;
  logic        hb_cs_n;
  logic        hb_ck_hi;
  logic        hb_ck_lo;
  logic [7:0]  hb_dq_o_hi;
  logic [7:0]  hb_dq_o_lo;
  logic [7:0]  hb_dq_oe;
  logic        hb_rwds_o_hi;
  logic        hb_rwds_o_lo;
  logic [7:0]  hb_dq_i_hi;
  logic [7:0]  hb_dq_i_lo;
  logic        hb_rwds_i_hi;
  logic        hb_rwds_i_lo;
  logic [15:0] cr0;
  logic [15:0] cr1;
  logic        busy;
  logic        err;

  hbram_target_emu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hb_rst_n     (hb_rst_n),
    .hb_cs_n      (hb_cs_n),
    .hb_ck_hi     (hb_ck_hi),
    .hb_ck_lo     (hb_ck_lo),
    .hb_dq_o_hi   (hb_dq_o_hi),
    .hb_dq_o_lo   (hb_dq_o_lo),
    .hb_dq_oe     (hb_dq_oe),
    .hb_rwds_o_hi (hb_rwds_o_hi),
    .hb_rwds_o_lo (hb_rwds_o_lo),
    .hb_dq_i_hi   (hb_dq_i_hi),
    .hb_dq_i_lo   (hb_dq_i_lo),
    .hb_rwds_i_hi (hb_rwds_i_hi),
    .hb_rwds_i_lo (hb_rwds_i_lo),
    .cr0          (cr0),
    .cr1          (cr1),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] wbuf  [16];
  logic [1:0]  mbuf  [16];
  logic [15:0] rbuf  [16];
  logic [1:0]  rwbuf [16];
  logic [1:0]  ca_rwds;
  logic        ca_busy;
  logic [15:0] pre_dq;
  logic [1:0]  pre_rwds;
  logic        last_busy;

  typedef struct {
    bit          wr;
    bit          as;
    logic [31:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [16];
  int   nv = 0;

  task automatic add_vec(input bit wr, input bit as, input logic [31:0] addr,
                         input logic [15:0] data, input logic [1:0] mask,
                         input logic [15:0] exp, input string name);
    vecs[nv].wr   = wr;
    vecs[nv].as   = as;
    vecs[nv].addr = addr;
    vecs[nv].data = data;
    vecs[nv].mask = mask;
    vecs[nv].exp  = exp;
    vecs[nv].name = name;
    nv++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One active ck cycle carrying a 16-bit word and a 2-bit mask.
  task automatic cyc(input logic cs, input logic [15:0] d, input logic [1:0] m);
    @(negedge clk);
    hb_cs_n      = cs;
    hb_ck_hi     = 1'b1;
    hb_ck_lo     = 1'b0;
    hb_dq_o_hi   = d[15:8];
    hb_dq_o_lo   = d[7:0];
    hb_rwds_o_hi = m[1];
    hb_rwds_o_lo = m[0];
    @(posedge clk);
    #1;
  endtask

  // One clk with ck stalled.
  task automatic idle(input logic cs);
    @(negedge clk);
    hb_cs_n      = cs;
    hb_ck_hi     = 1'b0;
    hb_ck_lo     = 1'b0;
    hb_dq_o_hi   = 8'h00;
    hb_dq_o_lo   = 8'h00;
    hb_rwds_o_hi = 1'b0;
    hb_rwds_o_lo = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_ca(input bit rw, input bit as, input bit lin, input logic [31:0] addr);
    logic [47:0] ca;
    ca = {rw, as, lin, addr[31:3], 13'd0, addr[2:0]};
    cyc(1'b0, ca[47:32], 2'b00);
    ca_rwds = {hb_rwds_i_hi, hb_rwds_i_lo};
    ca_busy = busy;
    cyc(1'b0, ca[31:16], 2'b00);
    cyc(1'b0, ca[15:0], 2'b00);
  endtask

  // Full memory/register burst of n words, optional stalled ck before word idle_at.
  task automatic xfer(input bit rw, input bit as, input bit lin, input logic [31:0] addr,
                      input int n, input int idle_at);
    send_ca(rw, as, lin, addr);
    for (int i = 0; i < N_LAT; i++) cyc(1'b0, 16'h0000, 2'b00);
    pre_dq   = {hb_dq_i_hi, hb_dq_i_lo};
    pre_rwds = {hb_rwds_i_hi, hb_rwds_i_lo};
    for (int k = 0; k < n; k++) begin
      if (k == idle_at) idle(1'b0);
      cyc(1'b0, rw ? 16'h0000 : wbuf[k], rw ? 2'b00 : mbuf[k]);
      rbuf[k]  = {hb_dq_i_hi, hb_dq_i_lo};
      rwbuf[k] = {hb_rwds_i_hi, hb_rwds_i_lo};
    end
    last_busy = busy;
    idle(1'b1);
  endtask

  task automatic reg_write(input logic [31:0] addr, input logic [15:0] d);
    send_ca(1'b0, 1'b1, 1'b1, addr);
    cyc(1'b0, d, 2'b00);
    idle(1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    hb_rst_n     = 1'b1;
    hb_cs_n      = 1'b1;
    hb_ck_hi     = 1'b0;
    hb_ck_lo     = 1'b0;
    hb_dq_o_hi   = 8'h00;
    hb_dq_o_lo   = 8'h00;
    hb_dq_oe     = 8'h00;
    hb_rwds_o_hi = 1'b0;
    hb_rwds_o_lo = 1'b0;

    // Single-word vectors: register reads at reset, byte masking, top address.
    add_vec(0, 1, 32'h800, 16'h0000, 2'b00, 16'h8F1F, "cr0_reset_read");
    add_vec(0, 1, 32'h801, 16'h0000, 2'b00, 16'h0002, "cr1_reset_read");
    add_vec(0, 1, 32'h802, 16'h0000, 2'b00, 16'h0000, "reg_unmapped_read");
    add_vec(1, 0, 32'h020, 16'h1234, 2'b00, 16'h0000, "");
    add_vec(1, 0, 32'h020, 16'hABCD, 2'b10, 16'h0000, "");
    add_vec(0, 0, 32'h020, 16'h0000, 2'b00, 16'h12CD, "mask_hi_read");
    add_vec(1, 0, 32'h021, 16'h5678, 2'b00, 16'h0000, "");
    add_vec(1, 0, 32'h021, 16'h9A00, 2'b01, 16'h0000, "");
    add_vec(0, 0, 32'h021, 16'h0000, 2'b00, 16'h9A78, "mask_lo_read");
    add_vec(1, 0, 32'h3FF, 16'hCAFE, 2'b00, 16'h0000, "");
    add_vec(1, 0, 32'h3FF, 16'hBEEF, 2'b11, 16'h0000, "");
    add_vec(0, 0, 32'h3FF, 16'h0000, 2'b00, 16'hCAFE, "mask_all_read");

    repeat (3) @(posedge clk);
    #1;
    check("reset_dq",   {hb_dq_i_hi, hb_dq_i_lo}, 16'h0000);
    check("reset_rwds", {hb_rwds_i_hi, hb_rwds_i_lo}, 2'b00);
    check("reset_cr0",  cr0, 16'h8F1F);
    check("reset_cr1",  cr1, 16'h0002);
    check("reset_busy", busy, 1'b0);
    check("reset_err",  err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);

    // Table-driven single-word transactions.
    for (int i = 0; i < nv; i++) begin
      if (vecs[i].wr) begin
        wbuf[0] = vecs[i].data;
        mbuf[0] = vecs[i].mask;
        xfer(1'b0, vecs[i].as, 1'b1, vecs[i].addr, 1, -1);
      end else begin
        xfer(1'b1, vecs[i].as, 1'b1, vecs[i].addr, 1, -1);
        check(vecs[i].name, rbuf[0], vecs[i].exp);
        check({vecs[i].name, "_rwds"}, rwbuf[0], 2'b10);
      end
    end

    // Linear 4-word write then read back with a stalled ck before word 2.
    for (int k = 0; k < 4; k++) begin
      wbuf[k] = 16'h1111 * 16'(k + 1);
      mbuf[k] = 2'b00;
    end
    xfer(1'b0, 1'b0, 1'b1, 32'h10, 4, -1);
    check("ca_rwds_fixed", ca_rwds, 2'b11);
    check("ca_busy", ca_busy, 1'b1);
    xfer(1'b1, 1'b0, 1'b1, 32'h10, 4, 2);
    check("lat_last_dq", pre_dq, 16'h0000);
    check("lat_last_rwds", pre_rwds, 2'b00);
    for (int k = 0; k < 4; k++) begin
      check("lin_read", rbuf[k], 16'h1111 * 16'(k + 1));
      check("lin_read_rwds", rwbuf[k], 2'b10);
    end
    check("idle_after", busy, 1'b0);

    // Linear burst crossing the top of memory wraps to word 0.
    wbuf[0] = 16'h7777; mbuf[0] = 2'b00;
    wbuf[1] = 16'h8888; mbuf[1] = 2'b00;
    xfer(1'b0, 1'b0, 1'b1, 32'h3FF, 2, -1);
    xfer(1'b1, 1'b0, 1'b1, 32'h000, 1, -1);
    check("lin_wrap_top", rbuf[0], 16'h8888);

    // Fill words 0..7 for the wrapped read.
    for (int k = 0; k < 8; k++) begin
      wbuf[k] = 16'hA000 + 16'(k);
      mbuf[k] = 2'b00;
    end
    xfer(1'b0, 1'b0, 1'b1, 32'h000, 8, -1);

    // CR0 write, then two-word register read across CR0/CR1.
    reg_write(32'h800, 16'h8F1E);
    check("cr0_written", cr0, 16'h8F1E);
    check("err_clean", err, 1'b0);
    xfer(1'b1, 1'b1, 1'b1, 32'h800, 2, -1);
    check("reg_read_cr0", rbuf[0], 16'h8F1E);
    check("reg_read_cr1", rbuf[1], 16'h0002);

    // Wrapped read, 8-word group: 6,7,0,1,...,7.
    xfer(1'b1, 1'b0, 1'b0, 32'h006, 10, -1);
    for (int k = 0; k < 10; k++) begin
      check("wrap_read", rbuf[k], 16'hA000 + 16'((6 + k) % 8));
    end

    // Register write to an unmapped address.
    reg_write(32'h900, 16'h1234);
    check("bad_reg_err", err, 1'b1);
    check("bad_reg_cr0", cr0, 16'h8F1E);
    check("bad_reg_cr1", cr1, 16'h0002);

    // Burst cut short by deselect after 2 of 4 words.
    for (int k = 0; k < 4; k++) begin
      wbuf[k] = 16'h0000;
      mbuf[k] = 2'b00;
    end
    xfer(1'b0, 1'b0, 1'b1, 32'h040, 4, -1);
    wbuf[0] = 16'hD001;
    wbuf[1] = 16'hD002;
    wbuf[2] = 16'hD003;
    wbuf[3] = 16'hD004;
    xfer(1'b0, 1'b0, 1'b1, 32'h040, 2, -1);
    check("partial_busy_before", last_busy, 1'b1);
    check("partial_busy_after", busy, 1'b0);
    xfer(1'b1, 1'b0, 1'b1, 32'h040, 4, -1);
    check("partial_w0", rbuf[0], 16'hD001);
    check("partial_w1", rbuf[1], 16'hD002);
    check("partial_w2", rbuf[2], 16'h0000);
    check("partial_w3", rbuf[3], 16'h0000);

    // Device reset pulse in the middle of a read burst.
    send_ca(1'b1, 1'b0, 1'b1, 32'h10);
    for (int i = 0; i < N_LAT; i++) cyc(1'b0, 16'h0000, 2'b00);
    cyc(1'b0, 16'h0000, 2'b00);
    cyc(1'b0, 16'h0000, 2'b00);
    check("midread_w1", {hb_dq_i_hi, hb_dq_i_lo}, 16'h2222);
    @(negedge clk);
    hb_rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("hbrst_busy", busy, 1'b0);
    check("hbrst_cr0", cr0, 16'h8F1F);
    check("hbrst_rwds", {hb_rwds_i_hi, hb_rwds_i_lo}, 2'b00);
    check("hbrst_err_sticky", err, 1'b1);
    @(negedge clk);
    hb_rst_n = 1'b1;
    idle(1'b1);
    xfer(1'b1, 1'b0, 1'b1, 32'h10, 4, -1);
    for (int k = 0; k < 4; k++) begin
      check("mem_kept", rbuf[k], 16'h1111 * 16'(k + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
